offset_gen_pipe: RTL and testbench

Parametrised, multi-lane, pipelined successor to the PE offset generator. Each lane computes the additive offset the PE accumulator needs for unary modes. Log mode maps the leading-one position of x to a programmable fixed-point table entry ≈ (pos − FRA_BW)·ln2. GEMM, div and exp modes yield zero. It sits between the operand fetch and the accumulator adder, uses a valid/ready handshake, and has a runtime-writable LUT plus a sticky domain-error flag.

---
 rtl/offset_gen_pkg.sv | 32 +++
 rtl/offset_gen_pipe_if.sv | 26 ++
 rtl/lead_one_enc.sv | 21 ++
 rtl/offset_gen_pipe.sv | 131 +++++++++++++
 tb/tb_offset_gen_pipe.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/offset_gen_pkg.sv
// rtl/offset_gen_pkg.sv - shared types and constant functions for offset_gen_pipe
// Contents: mode_e beat mode, ln2_q(), log_zero(), lut_default().
package offset_gen_pkg;

  typedef enum logic [1:0] {
    MODE_GEMM = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_EXP  = 2'b10,
    MODE_LOG  = 2'b11
  } mode_e;

  // ln2 scaled by 2^32, rounded to nearest; lets ln2_q() stay pure integer math.
  localparam logic [63:0] LN2_Q32 = 64'd2977044472;

  // round(ln2 * 2^fra_bw), valid for fra_bw in 1..31.
  function automatic longint ln2_q(input int fra_bw);
    logic [63:0] r;
    r = (LN2_Q32 + (64'd1 << (31 - fra_bw))) >> (32 - fra_bw);
    return longint'(r);
  endfunction

  // Most-negative value of an acc_bw-bit signed word, sign-extended to 64 bits.
  function automatic longint log_zero(input int acc_bw);
    return -(longint'(1) << (acc_bw - 1));
  endfunction

  // Default table entry k: (k - fra_bw) * ln2 in the fixed-point format.
  function automatic longint lut_default(input int k, input int fra_bw);
    return longint'(k - fra_bw) * ln2_q(fra_bw);
  endfunction

endpackage

// File: rtl/offset_gen_pipe_if.sv
// rtl/offset_gen_pipe_if.sv - beat handshake bundle for offset_gen_pipe
// Signals: mode_i/in_valid_i/x_i/in_ready_o (input beat), out_valid_o/out_ready_i/offset_o (output beat).
// slave = the offset generator, master = the producer/consumer side.
interface offset_gen_pipe_if #(
  parameter int LANES  = 4,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32
);
  logic [1:0]              mode_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [LANES*MUL_BW-1:0] x_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [LANES*ACC_BW-1:0] offset_o;

  modport slave (
    input  mode_i, in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, offset_o
  );

  modport master (
    output mode_i, in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, offset_o
  );
endinterface

// File: rtl/lead_one_enc.sv
// rtl/lead_one_enc.sv - leading-one index and non-positive flag of a signed word
// Ports: x_i (W, signed operand), idx_o (clog2(W), leading-one position 0..W-2),
//        nonpos_o (1, x_i <= 0; idx_o is meaningless when set).
module lead_one_enc #(
  parameter int W = 16
) (
  input  logic [W-1:0]         x_i,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 nonpos_o
);
  localparam int IW = $clog2(W);

  always_comb begin
    idx_o = '0;
    // Ascending scan: the last hit is the highest set magnitude bit.
    for (int i = 0; i < W - 1; i++) begin
      if (x_i[i]) idx_o = i[IW-1:0];
    end
    nonpos_o = x_i[W-1] | (x_i == '0);
  end
endmodule

// File: rtl/offset_gen_pipe.sv
// rtl/offset_gen_pipe.sv - two-stage multi-lane log-mode offset generator
// Ports: clk, rst_n (async active-low); bus (slave: mode_i, in_valid_i, x_i, in_ready_o,
//        out_valid_o, out_ready_i, offset_o); cfg_we_i/cfg_addr_i/cfg_data_i (LUT write);
//        err_zero_o (sticky log-domain error), clr_err_i (clear it).
module offset_gen_pipe
  import offset_gen_pkg::*;
#(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  offset_gen_pipe_if.slave          bus,
  input  logic                      cfg_we_i,
  input  logic [$clog2(MUL_BW)-1:0] cfg_addr_i,
  input  logic [ACC_BW-1:0]         cfg_data_i,
  output logic                      err_zero_o,
  input  logic                      clr_err_i
);
  localparam int AW    = $clog2(MUL_BW);
  localparam int LUT_N = MUL_BW - 1;
  localparam logic [AW-1:0]     LUT_LAST = AW'(LUT_N - 1);
  localparam logic [63:0]       LOG_ZERO_W = 64'(log_zero(ACC_BW));
  localparam logic [ACC_BW-1:0] LOG_ZERO = LOG_ZERO_W[ACC_BW-1:0];

  // Operand is sign + INT_BW + FRA_BW; the table indexing assumes that layout.
  if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_fmt_check
    $error("offset_gen_pipe: MUL_BW must equal 1 + INT_BW + FRA_BW");
  end

  function automatic logic [ACC_BW-1:0] lut_rst(input int k);
    logic [63:0] v;
    v = 64'(lut_default(k, FRA_BW));
    return v[ACC_BW-1:0];
  endfunction

  logic [AW-1:0]           lane_idx [LANES];
  logic [LANES-1:0]        lane_nonpos;

  logic                    s1_valid_q, s1_valid_d;
  mode_e                   s1_mode_q, s1_mode_d;
  logic [AW-1:0]           s1_idx_q [LANES];
  logic [AW-1:0]           s1_idx_d [LANES];
  logic [LANES-1:0]        s1_nonpos_q, s1_nonpos_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*ACC_BW-1:0] offset_q, offset_d;
  logic                    err_q, err_d;
  logic [ACC_BW-1:0]       lut_q [LUT_N];
  logic [ACC_BW-1:0]       lut_d [LUT_N];

  logic s1_adv, accept, err_set;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lead_one_enc #(.W(MUL_BW)) u_enc (
      .x_i      (bus.x_i[l*MUL_BW +: MUL_BW]),
      .idx_o    (lane_idx[l]),
      .nonpos_o (lane_nonpos[l])
    );
  end

  // Stage 1 may move whenever stage 2 is empty or its beat is leaving this cycle.
  assign s1_adv  = ~out_valid_q | bus.out_ready_i;
  assign accept  = bus.in_valid_i & bus.in_ready_o;
  assign err_set = s1_adv & s1_valid_q & (s1_mode_q == MODE_LOG) & (|s1_nonpos_q);

  assign bus.in_ready_o  = ~s1_valid_q | s1_adv;
  assign bus.out_valid_o = out_valid_q;
  assign bus.offset_o    = offset_q;
  assign err_zero_o      = err_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_idx_d    = s1_idx_q;
    s1_nonpos_d = s1_nonpos_q;
    out_valid_d = out_valid_q;
    offset_d    = offset_q;
    err_d       = err_q;
    lut_d       = lut_q;

    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      s1_valid_d  = 1'b0;
      // LUT is read from the current flops, so a same-cycle write is not seen here.
      if (s1_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          if (s1_mode_q != MODE_LOG)  offset_d[l*ACC_BW +: ACC_BW] = '0;
          else if (s1_nonpos_q[l])    offset_d[l*ACC_BW +: ACC_BW] = LOG_ZERO;
          else                        offset_d[l*ACC_BW +: ACC_BW] = lut_q[s1_idx_q[l]];
        end
      end
    end

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_mode_d   = mode_e'(bus.mode_i);
      s1_idx_d    = lane_idx;
      s1_nonpos_d = lane_nonpos;
    end

    if (err_set)        err_d = 1'b1;
    else if (clr_err_i) err_d = 1'b0;

    if (cfg_we_i && (cfg_addr_i <= LUT_LAST)) lut_d[cfg_addr_i] = cfg_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_GEMM;
      s1_nonpos_q <= '0;
      out_valid_q <= 1'b0;
      offset_q    <= '0;
      err_q       <= 1'b0;
      for (int l = 0; l < LANES; l++) s1_idx_q[l] <= '0;
      for (int k = 0; k < LUT_N; k++) lut_q[k] <= lut_rst(k);
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_idx_q    <= s1_idx_d;
      s1_nonpos_q <= s1_nonpos_d;
      out_valid_q <= out_valid_d;
      offset_q    <= offset_d;
      err_q       <= err_d;
      lut_q       <= lut_d;
    end
  end
endmodule

// File: tb/tb_offset_gen_pipe.sv
// tb/tb_offset_gen_pipe.sv - self-checking bench for offset_gen_pipe
module tb_offset_gen_pipe;
  localparam int LANES  = 4;
  localparam int MUL_BW = 16;
  localparam int ACC_BW = 32;
  localparam int AW     = $clog2(MUL_BW);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [ACC_BW-1:0] cfg_data = '0;
  logic              clr_err = 1'b0;
  logic              err_zero;

  offset_gen_pipe_if #(.LANES(LANES), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW)) bus ();

  offset_gen_pipe #(
    .INT_BW(5), .FRA_BW(10), .MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .LANES(LANES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .err_zero_o (err_zero),
    .clr_err_i  (clr_err)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int n_beats   = 0;
  logic [LANES*ACC_BW-1:0] exp_q [$];
  logic [ACC_BW-1:0]       lut_m [MUL_BW-1];
  logic [LANES*ACC_BW-1:0] snap;

  function automatic void lut_model_reset();
    for (int k = 0; k < MUL_BW - 1; k++) lut_m[k] = 32'((k - 10) * 710);
  endfunction

  function automatic logic [ACC_BW-1:0] lane_exp(input logic [1:0] mode, input logic [15:0] x);
    if (mode != 2'b11) return '0;
    if (x[15] || x == 16'h0000) return 32'h8000_0000;
    for (int i = 14; i >= 0; i--) if (x[i]) return lut_m[i];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] mode, input logic [15:0] x0, x1, x2, x3);
    int budget = 0;
    bus.mode_i     = mode;
    bus.x_i        = {x3, x2, x1, x0};
    bus.in_valid_i = 1'b1;
    #1;
    while (!bus.in_ready_o && budget < 50) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("accept_timeout", 128'(bus.in_ready_o), 128'(1));
    exp_q.push_back({lane_exp(mode, x3), lane_exp(mode, x2), lane_exp(mode, x1), lane_exp(mode, x0)});
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 20) begin
      tick();
      b++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // Scoreboard: every delivered beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      logic [LANES*ACC_BW-1:0] e;
      n_asserts++;
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          n_fails++;
          $error("FAIL beat_extra observed=%0h expected=none", bus.offset_o);
        end
      end else begin
        e = exp_q.pop_front();
        assert (bus.offset_o === e) else begin
          n_fails++;
          $error("FAIL beat%0d observed=%0h expected=%0h", n_beats, bus.offset_o, e);
        end
      end
      n_beats++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.mode_i      = 2'b00;
    bus.x_i         = '0;
    bus.out_ready_i = 1'b1;
    lut_model_reset();
    repeat (3) tick();
    check("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("rst_offset", 128'(bus.offset_o), 128'(0));
    check("rst_err", 128'(err_zero), 128'(0));
    rst_n = 1'b1;
    tick();

    // First log beat with latency check.
    send(2'b11, 16'h0400, 16'h4000, 16'h0001, 16'h7FFF);
    check("lat_cycle1_valid", 128'(bus.out_valid_o), 128'(0));
    tick();
    check("lat_cycle2_valid", 128'(bus.out_valid_o), 128'(1));
    check("log_basic", 128'(bus.offset_o), {64'h0, 32'd2840, 32'hFFFF_E444, 32'd2840, 32'd0});
    drain();

    // Non-log modes back-to-back, then a log beat.
    send(2'b00, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send(2'b01, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send(2'b10, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send(2'b11, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    drain();
    check("modes_err_clear", 128'(err_zero), 128'(0));

    // Domain error: set, hold, clear, then set-wins.
    send(2'b11, 16'h0400, 16'h0400, 16'h0000, 16'h8000);
    tick();
    check("err_lanes_logzero", 128'(bus.offset_o[127:64]), 128'(64'h8000_0000_8000_0000));
    check("err_set", 128'(err_zero), 128'(1));
    repeat (3) tick();
    check("err_sticky", 128'(err_zero), 128'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_cleared", 128'(err_zero), 128'(0));
    send(2'b11, 16'h0001, 16'h0001, 16'h8000, 16'h0001);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_set_wins", 128'(err_zero), 128'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_cleared2", 128'(err_zero), 128'(0));
    drain();

    // LUT write coinciding with the stage 1->2 transfer.
    send(2'b11, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    cfg_we   = 1'b1;
    cfg_addr = 4'd10;
    cfg_data = 32'h55;
    lut_m[10] = 32'h55;
    send(2'b11, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    cfg_we = 1'b0;
    check("wr_same_cycle_old", 128'(bus.offset_o), 128'(0));
    tick();
    check("wr_next_beat_new", 128'(bus.offset_o), {64'h0, {4{32'h55}}} >> 0);
    cfg_we   = 1'b1;
    cfg_addr = 4'd15;
    cfg_data = 32'hDEAD;
    tick();
    cfg_we = 1'b0;
    send(2'b11, 16'h0001, 16'h0400, 16'h4000, 16'h7FFF);
    drain();

    // Backpressure: two beats fill the pipe, output must hold.
    bus.out_ready_i = 1'b0;
    send(2'b11, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    send(2'b11, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    bus.mode_i     = 2'b11;
    bus.x_i        = {4{16'h0100}};
    bus.in_valid_i = 1'b1;
    #1;
    check("hold_ready_drop", 128'(bus.in_ready_o), 128'(0));
    snap = bus.offset_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready_low", 128'(bus.in_ready_o), 128'(0));
      check("hold_valid", 128'(bus.out_valid_o), 128'(1));
      check("hold_offset_stable", 128'(bus.offset_o), 128'(snap));
    end
    bus.out_ready_i = 1'b1;
    send(2'b11, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    drain();

    // Reset mid-stream with two beats in flight.
    send(2'b11, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    send(2'b11, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("midrst_offset", 128'(bus.offset_o), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready_o), 128'(1));
    exp_q.delete();
    lut_model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(2'b11, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    tick();
    check("lut_default_restored", 128'(bus.offset_o), 128'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
